// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared states, op_sel codes and default widths for the multiply/divide sequencer
package multdiv_pkg;

    localparam int MD_DATA_W = 32;
    localparam int MD_ITER   = MD_DATA_W;
    localparam int MD_CNT_W  = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } md_state_e;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;

    // Radix-2 Booth recoding of {multiplier LSB, extra bit}.
    function automatic logic [1:0] booth_op(input logic [1:0] bits);
        case (bits)
            2'b01:   return OP_ADD;
            2'b10:   return OP_SUB;
            default: return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/multdiv_ctrl_if.sv
// rtl/multdiv_ctrl_if.sv - datapath/pipeline bundle of the sequencer; perf_cycles exists only with MULTDIV_CYCLE_CNT_EN
interface multdiv_ctrl_if #(
    parameter int CNT_W = 6
);

    logic             ctrl_mult;
    logic             ctrl_div;
    logic [1:0]       booth_bits;
    logic             rem_sign;
    logic             divisor_zero;
    logic             mult_overflow;

    logic             reg_ie;
    logic             reg_load;
    logic [1:0]       op_sel;
    logic             shift_en;
    logic             is_div;
    logic             busy;
    logic [CNT_W-1:0] iter_count;
    logic             result_ready;
    logic             exception;
`ifdef MULTDIV_CYCLE_CNT_EN
    logic [31:0]      perf_cycles;
`endif

    modport master (
        output ctrl_mult, ctrl_div, booth_bits, rem_sign, divisor_zero, mult_overflow,
`ifdef MULTDIV_CYCLE_CNT_EN
        input  perf_cycles,
`endif
        input  reg_ie, reg_load, op_sel, shift_en, is_div, busy, iter_count,
               result_ready, exception
    );

    modport slave (
        input  ctrl_mult, ctrl_div, booth_bits, rem_sign, divisor_zero, mult_overflow,
`ifdef MULTDIV_CYCLE_CNT_EN
        output perf_cycles,
`endif
        output reg_ie, reg_load, op_sel, shift_en, is_div, busy, iter_count,
               result_ready, exception
    );

endinterface

// File: rtl/multdiv_iter_counter.sv
// rtl/multdiv_iter_counter.sv - iteration counter: clear, enable, saturate at ITER, last-step flag
module multdiv_iter_counter #(
    parameter int ITER  = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             i_clear,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_last
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!clr_n || i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;
    // High during the step that will complete the ITER-th iteration.
    assign o_last  = (r_count == CNT_LAST);

endmodule

// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - Booth multiply / non-restoring divide sequencer; MULTDIV_CYCLE_CNT_EN adds perf_cycles
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int DATA_W = MD_DATA_W,
    parameter int ITER   = DATA_W,
    parameter int CNT_W  = MD_CNT_W
) (
    input  logic          clk,
    input  logic          clr_n,
    multdiv_ctrl_if.slave bus
);

    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_LOAD = ST_LOAD;
    localparam logic [2:0] S_RUN  = ST_RUN;
    localparam logic [2:0] S_FIX  = ST_FIX;
    localparam logic [2:0] S_DONE = ST_DONE;

    if (ITER < 1 || ITER > DATA_W || (2 ** CNT_W) <= ITER) begin : g_cfg_check
        $error("multdiv_ctrl: ITER must be 1..DATA_W and below 2**CNT_W");
    end

    logic [2:0]       r_state;
    logic             r_is_div;
    logic             r_exc;

    logic             w_in_load;
    logic             w_in_run;
    logic             w_in_fix;
    logic             w_in_done;
    logic             w_busy;
    logic             w_last;
    logic [CNT_W-1:0] w_count;
    logic [1:0]       w_op_sel;

    assign w_in_load = (r_state == S_LOAD);
    assign w_in_run  = (r_state == S_RUN);
    assign w_in_fix  = (r_state == S_FIX);
    assign w_in_done = (r_state == S_DONE);
    assign w_busy    = w_in_load | w_in_run | w_in_fix;

    multdiv_iter_counter #(
        .ITER  (ITER),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk     (clk),
        .clr_n   (clr_n),
        .i_clear (w_in_load),
        .i_en    (w_in_run),
        .o_count (w_count),
        .o_last  (w_last)
    );

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state  <= S_IDLE;
            r_is_div <= 1'b0;
            r_exc    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Multiply has priority when both starts arrive together.
                    if (bus.ctrl_mult) begin
                        r_state  <= S_LOAD;
                        r_is_div <= 1'b0;
                        r_exc    <= 1'b0;
                    end else if (bus.ctrl_div) begin
                        r_state  <= S_LOAD;
                        r_is_div <= 1'b1;
                        r_exc    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (r_is_div && bus.divisor_zero) begin
                        r_exc   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_last) begin
                        if (r_is_div) begin
                            r_state <= S_FIX;
                        end else begin
                            r_exc   <= bus.mult_overflow;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_FIX:   r_state <= S_DONE;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Divide restores a negative final remainder by adding the divisor back once.
    always_comb begin
        w_op_sel = OP_NONE;
        if (w_in_run) begin
            if (r_is_div) begin
                w_op_sel = bus.rem_sign ? OP_ADD : OP_SUB;
            end else begin
                w_op_sel = booth_op(bus.booth_bits);
            end
        end else if (w_in_fix && bus.rem_sign) begin
            w_op_sel = OP_ADD;
        end
    end

    assign bus.reg_ie       = w_busy;
    assign bus.reg_load     = w_in_load;
    assign bus.op_sel       = w_op_sel;
    assign bus.shift_en     = w_in_run;
    assign bus.is_div       = r_is_div & (r_state != S_IDLE);
    assign bus.busy         = w_busy;
    assign bus.iter_count   = w_count;
    assign bus.result_ready = w_in_done;
    assign bus.exception    = w_in_done & r_exc;

`ifdef MULTDIV_CYCLE_CNT_EN
    logic [31:0] r_perf_cycles;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_perf_cycles <= '0;
        end else if (w_busy) begin
            r_perf_cycles <= r_perf_cycles + 32'd1;
        end
    end

    assign bus.perf_cycles = r_perf_cycles;
`endif

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Sequencer for the 65-bit product/remainder register of the multiply/divide unit.
- Accepts a start pulse for multiply or divide and drives the register's write enable, initial-load select, ALU add/sub select and shift enable, one step per cycle.
- Runs radix-2 Booth multiply and non-restoring divide, then signals result_ready and exception to the pipeline stall logic.

Parameters:
- DATA_W, 32, operand width; the product register is 2*DATA_W+1 bits.
- ITER, DATA_W, number of iteration cycles per operation.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > ITER.

Ports:
- clk  in  1  rising-edge clock
- clr_n  in  1  synchronous active-low reset
- ctrl_mult  in  1  multiply start pulse
- ctrl_div  in  1  divide start pulse
- booth_bits  in  2  product register bits [1:0] (multiplier LSB, extra bit)
- rem_sign  in  1  sign bit of the current remainder (upper half MSB)
- divisor_zero  in  1  divisor operand equals 0
- mult_overflow  in  1  datapath flag: upper DATA_W+1 product bits are not a pure sign extension
- reg_ie  out  1  product register input enable
- reg_load  out  1  select initial operand load into the register
- op_sel  out  2  00 none, 01 add, 10 sub, 11 reserved (never driven)
- shift_en  out  1  arithmetic shift (multiply right / divide left) this step
- is_div  out  1  current operation is a divide
- busy  out  1  operation in progress
- iter_count  out  CNT_W  completed iterations
- result_ready  out  1  one-cycle pulse: result valid in the register
- exception  out  1  valid only with result_ready

Behaviour:
- Reset (clr_n=0 at a clk edge): state IDLE; every output 0; counter 0. A reset mid-operation aborts it with no result_ready pulse.
- States: IDLE, LOAD, RUN, FIX, DONE.
- IDLE:
  - ctrl_mult=1 -> LOAD, is_div=0.
  - else ctrl_div=1 -> LOAD, is_div=1.
  - Both high: multiply wins; the divide is dropped.
  - Start pulses in any other state are ignored.
- LOAD (1 cycle): reg_ie=1, reg_load=1, counter cleared.
  - is_div and divisor_zero -> DONE with exception latched 1.
  - else -> RUN.
- RUN (ITER cycles): reg_ie=1, shift_en=1; counter increments each cycle.
  - Multiply: booth_bits 01 -> add, 10 -> sub, 00/11 -> none.
  - Divide: rem_sign=0 -> sub, 1 -> add.
  - After the ITER-th cycle: multiply -> DONE and latch exception=mult_overflow; divide -> FIX.
- FIX (divide only, 1 cycle): reg_ie=1, shift_en=0, op_sel=add if rem_sign=1, else none; -> DONE.
- DONE (1 cycle): result_ready=1, exception as latched, busy=0 -> IDLE.
- busy=1 in LOAD, RUN and FIX.
- Latency, start sampled at edge t:
  - Multiply: result_ready high in cycle t+ITER+2 (34).
  - Divide: t+ITER+3 (35).
  - Divide by zero: t+2.
- A new start is accepted in IDLE on the edge right after DONE, so back-to-back throughput is one operation per latency+1 cycles.
- The counter saturates at ITER and never wraps.

Optional Feature:
- MULTDIV_CYCLE_CNT_EN defined:
  - Adds output perf_cycles (32 bits): free-running count of cycles with busy=1.
  - Cleared only by clr_n; wraps modulo 2^32.
- Not defined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- multdiv_pkg holds:
  - state enum: IDLE, LOAD, RUN, FIX, DONE
  - op_sel encodings OP_NONE, OP_ADD, OP_SUB
  - default DATA_W/ITER constants
- One sub-module, multdiv_iter_counter: clear, enable, saturate at ITER, terminal-count flag.

Test Plan:
- Multiply 7*3: ctrl_mult pulse, drive booth_bits from a model register -> reg_load for 1 cycle, 32 RUN cycles with op_sel matching the Booth table, result_ready at cycle 34, exception=0.
- Divide 100/7 with rem_sign from a model -> 32 RUN cycles, FIX asserts add only if the final rem_sign=1, result_ready at cycle 35, exception=0.
- Divide by zero: ctrl_div with divisor_zero=1 -> result_ready and exception=1 at cycle 2, no RUN cycles (reg_ie low after LOAD).
- Overflow: 0x7FFFFFFF*4 with mult_overflow=1 at the end -> exception=1 with the result_ready pulse.
- Contention: ctrl_mult and ctrl_div both high -> is_div=0. ctrl_div pulse during RUN -> ignored, busy unchanged, single result_ready.
- Reset mid-RUN at iter_count=10 -> next cycle all outputs 0, no result_ready. A new ctrl_mult then completes normally in 34 cycles; with MULTDIV_CYCLE_CNT_EN, perf_cycles reflects the aborted plus completed busy cycles only if reset is excluded; expect 33 after the post-reset op.
